// File: rtl/stream_merge_4_1.sv
// Four-input round-robin merge into an output FIFO: a word accepted at one edge is visible the next cycle.
// Inputs are acked only while ap_start is high and the FIFO is not full; STREAM_MERGE_STATS_EN adds per-input transfer counters.
module stream_merge_4_1 #(
   parameter int PAYLOAD_BITS = 32,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic                    ap_start,
   output logic                    ap_idle,
   input  logic [PAYLOAD_BITS-1:0] Input_1_V_V,
   input  logic                    Input_1_V_V_ap_vld,
   output logic                    Input_1_V_V_ap_ack,
   input  logic [PAYLOAD_BITS-1:0] Input_2_V_V,
   input  logic                    Input_2_V_V_ap_vld,
   output logic                    Input_2_V_V_ap_ack,
   input  logic [PAYLOAD_BITS-1:0] Input_3_V_V,
   input  logic                    Input_3_V_V_ap_vld,
   output logic                    Input_3_V_V_ap_ack,
   input  logic [PAYLOAD_BITS-1:0] Input_4_V_V,
   input  logic                    Input_4_V_V_ap_vld,
   output logic                    Input_4_V_V_ap_ack,
`ifdef STREAM_MERGE_STATS_EN
   output logic [15:0]             stat_in_1_cnt,
   output logic [15:0]             stat_in_2_cnt,
   output logic [15:0]             stat_in_3_cnt,
   output logic [15:0]             stat_in_4_cnt,
`endif
   output logic [PAYLOAD_BITS-1:0] Output_1_V_V,
   output logic                    Output_1_V_V_ap_vld,
   input  logic                    Output_1_V_V_ap_ack
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW:0]             count;
   logic [1:0]              prio;

   logic [3:0]              in_vld;
   logic [3:0]              in_ack;
   logic                    grant_any;
   logic [1:0]              grant_idx;
   logic [1:0]              cand;
   logic [PAYLOAD_BITS-1:0] in_sel;
   logic                    push;
   logic                    pop;

   assign in_vld = {Input_4_V_V_ap_vld, Input_3_V_V_ap_vld,
                    Input_2_V_V_ap_vld, Input_1_V_V_ap_vld};

   // Scan from the highest offset down so the last hit is the one closest to prio.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 2'd0;
      cand      = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         cand = prio + 2'(i);
         if (in_vld[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      in_sel = Input_1_V_V;
      case (grant_idx)
         2'd0:    in_sel = Input_1_V_V;
         2'd1:    in_sel = Input_2_V_V;
         2'd2:    in_sel = Input_3_V_V;
         default: in_sel = Input_4_V_V;
      endcase
   end

   // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
   assign push   = grant_any & ap_start & ~ap_rst & (count != CNT_FULL);
   assign pop    = (count != '0) & Output_1_V_V_ap_ack;
   assign in_ack = push ? (4'b0001 << grant_idx) : 4'b0000;

   assign Input_1_V_V_ap_ack = in_ack[0];
   assign Input_2_V_V_ap_ack = in_ack[1];
   assign Input_3_V_V_ap_ack = in_ack[2];
   assign Input_4_V_V_ap_ack = in_ack[3];

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         prio   <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            prio   <= grant_idx + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem[wr_ptr] <= in_sel;
      end
   end

   // Storage is not cleared on reset; the empty-gate keeps stale words off the output.
   assign Output_1_V_V_ap_vld = (count != '0);
   assign Output_1_V_V        = (count != '0) ? mem[rd_ptr] : '0;
   assign ap_idle             = (count == '0) && (in_vld == 4'b0000);

`ifdef STREAM_MERGE_STATS_EN
   logic [15:0] stat_cnt [4];

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         for (int k = 0; k < 4; k++) begin
            stat_cnt[k] <= 16'd0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (in_ack[k]) begin
               stat_cnt[k] <= stat_cnt[k] + 16'd1;
            end
         end
      end
   end

   assign stat_in_1_cnt = stat_cnt[0];
   assign stat_in_2_cnt = stat_cnt[1];
   assign stat_in_3_cnt = stat_cnt[2];
   assign stat_in_4_cnt = stat_cnt[3];
`endif

endmodule

// File: tb/tb_stream_merge_4_1.sv
// Directed bench for stream_merge_4_1; define STREAM_MERGE_STATS_EN to exercise the counters.
module tb_stream_merge_4_1;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b0;
   logic        ap_start = 1'b0;
   logic        ap_idle;
   logic [31:0] in_dat [4];
   logic [3:0]  in_vld = 4'b0000;
   logic [3:0]  in_ack;
   logic [31:0] out_dat;
   logic        out_vld;
   logic        out_ack = 1'b0;
`ifdef STREAM_MERGE_STATS_EN
   logic [15:0] stat1, stat2, stat3, stat4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ap_clk = ~ap_clk;

   stream_merge_4_1 #(.PAYLOAD_BITS(32), .FIFO_DEPTH(4)) dut (
      .ap_clk              (ap_clk),
      .ap_rst              (ap_rst),
      .ap_start            (ap_start),
      .ap_idle             (ap_idle),
      .Input_1_V_V         (in_dat[0]),
      .Input_1_V_V_ap_vld  (in_vld[0]),
      .Input_1_V_V_ap_ack  (in_ack[0]),
      .Input_2_V_V         (in_dat[1]),
      .Input_2_V_V_ap_vld  (in_vld[1]),
      .Input_2_V_V_ap_ack  (in_ack[1]),
      .Input_3_V_V         (in_dat[2]),
      .Input_3_V_V_ap_vld  (in_vld[2]),
      .Input_3_V_V_ap_ack  (in_ack[2]),
      .Input_4_V_V         (in_dat[3]),
      .Input_4_V_V_ap_vld  (in_vld[3]),
      .Input_4_V_V_ap_ack  (in_ack[3]),
`ifdef STREAM_MERGE_STATS_EN
      .stat_in_1_cnt       (stat1),
      .stat_in_2_cnt       (stat2),
      .stat_in_3_cnt       (stat3),
      .stat_in_4_cnt       (stat4),
`endif
      .Output_1_V_V        (out_dat),
      .Output_1_V_V_ap_vld (out_vld),
      .Output_1_V_V_ap_ack (out_ack)
   );

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_reset;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b1;
      in_vld = 4'b0000;
      #2;
      ap_rst = 1'b0;
   endtask

   task automatic test_reset;
      for (int k = 0; k < 4; k++) in_dat[k] = 32'h0;
      in_vld   = 4'b1111;
      ap_start = 1'b1;
      #2;
      ap_rst = 1'b1;
      #1;
      n_checks++; if (in_ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b required 0000", in_ack); end
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_out_vld: got %b required 0", out_vld); end
      n_checks++; if (out_dat !== 32'h0) begin n_fail++; $display("FAIL rst_out_dat: got %h required 0", out_dat); end
      n_checks++; if (ap_idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b required 0", ap_idle); end
      in_vld = 4'b0000;
      #1;
      n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b required 1", ap_idle); end
      tick;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_release_vld: got %b required 0", out_vld); end
      tick;
   endtask

   task automatic test_single_word;
      ap_start  = 1'b1;
      out_ack   = 1'b1;
      in_dat[1] = 32'hA5A5_0002;
      in_vld    = 4'b0010;
      @(negedge ap_clk);
      n_checks++; if (in_ack !== 4'b0010) begin n_fail++; $display("FAIL single_ack: got %b required 0010", in_ack); end
      tick;
      in_vld = 4'b0000;
      @(negedge ap_clk);
      n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b required 1", out_vld); end
      n_checks++; if (out_dat !== 32'hA5A5_0002) begin n_fail++; $display("FAIL single_dat: got %h required a5a50002", out_dat); end
      tick;
      @(negedge ap_clk);
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b required 0", out_vld); end
      n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b required 1", ap_idle); end
   endtask

   task automatic test_round_robin;
      logic [3:0]  exp_ack;
      logic [31:0] exp_dat;
      do_reset;
      for (int k = 0; k < 4; k++) in_dat[k] = 32'(k + 1);
      ap_start = 1'b1;
      out_ack  = 1'b1;
      in_vld   = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         @(negedge ap_clk);
         exp_ack = 4'b0001 << (j % 4);
         n_checks++; if (in_ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b required %b", j, in_ack, exp_ack); end
         if (j > 0) begin
            exp_dat = 32'(((j - 1) % 4) + 1);
            n_checks++; if (out_dat !== exp_dat) begin n_fail++; $display("FAIL rr_dat[%0d]: got %h required %h", j, out_dat, exp_dat); end
         end
         tick;
      end
      in_vld = 4'b0000;
      @(negedge ap_clk);
      n_checks++; if (out_vld !== 1'b1 || out_dat !== 32'h1) begin n_fail++; $display("FAIL rr_last: got vld %b dat %h required vld 1 dat 00000001", out_vld, out_dat); end
      tick;
   endtask

   task automatic test_full_backpressure;
      int          acks;
      logic [31:0] exp_dat;
      do_reset;
      acks      = 0;
      out_ack   = 1'b0;
      ap_start  = 1'b1;
      in_dat[2] = 32'd10;
      in_vld    = 4'b0100;
      for (int c = 0; c < 8; c++) begin
         @(negedge ap_clk);
         if (in_ack[2]) acks++;
         tick;
         in_dat[2] = 32'(10 + acks);
      end
      n_checks++; if (acks != 4) begin n_fail++; $display("FAIL full_ack_count: got %0d required 4", acks); end
      out_ack = 1'b1;
      @(negedge ap_clk);
      n_checks++; if (in_ack !== 4'b0000) begin n_fail++; $display("FAIL full_prepop_ack: got %b required 0000", in_ack); end
      n_checks++; if (out_dat !== 32'd10) begin n_fail++; $display("FAIL full_head: got %0d required 10", out_dat); end
      tick;
      @(negedge ap_clk);
      n_checks++; if (in_ack !== 4'b0100) begin n_fail++; $display("FAIL full_fifth_ack: got %b required 0100", in_ack); end
      n_checks++; if (out_dat !== 32'd11) begin n_fail++; $display("FAIL full_dat11: got %0d required 11", out_dat); end
      tick;
      in_vld = 4'b0000;
      for (int j = 12; j <= 14; j++) begin
         @(negedge ap_clk);
         exp_dat = 32'(j);
         n_checks++; if (out_vld !== 1'b1 || out_dat !== exp_dat) begin n_fail++; $display("FAIL full_drain_%0d: got vld %b dat %0d required vld 1 dat %0d", j, out_vld, out_dat, exp_dat); end
         tick;
      end
      @(negedge ap_clk);
      n_checks++; if (out_vld !== 1'b0 || ap_idle !== 1'b1) begin n_fail++; $display("FAIL full_empty: got vld %b idle %b required vld 0 idle 1", out_vld, ap_idle); end
   endtask

   task automatic test_start_gating;
      do_reset;
      out_ack   = 1'b0;
      ap_start  = 1'b1;
      in_dat[0] = 32'h21;
      in_vld    = 4'b0001;
      tick;
      in_dat[0] = 32'h22;
      tick;
      ap_start = 1'b0;
      in_vld   = 4'b1111;
      out_ack  = 1'b1;
      @(negedge ap_clk);
      n_checks++; if (in_ack !== 4'b0000) begin n_fail++; $display("FAIL gate_ack0: got %b required 0000", in_ack); end
      n_checks++; if (out_dat !== 32'h21) begin n_fail++; $display("FAIL gate_dat21: got %h required 21", out_dat); end
      n_checks++; if (ap_idle !== 1'b0) begin n_fail++; $display("FAIL gate_idle: got %b required 0", ap_idle); end
      tick;
      @(negedge ap_clk);
      n_checks++; if (in_ack !== 4'b0000) begin n_fail++; $display("FAIL gate_ack1: got %b required 0000", in_ack); end
      n_checks++; if (out_dat !== 32'h22) begin n_fail++; $display("FAIL gate_dat22: got %h required 22", out_dat); end
      tick;
      @(negedge ap_clk);
      n_checks++; if (out_vld !== 1'b0 || in_ack !== 4'b0000) begin n_fail++; $display("FAIL gate_drained: got vld %b ack %b required vld 0 ack 0000", out_vld, in_ack); end
      in_vld   = 4'b0000;
      ap_start = 1'b1;
   endtask

   task automatic test_reset_mid;
      do_reset;
      out_ack  = 1'b0;
      ap_start = 1'b1;
      in_vld   = 4'b0010;
      for (int j = 0; j < 3; j++) begin
         in_dat[1] = 32'(31 + j);
         tick;
      end
      for (int k = 0; k < 4; k++) in_dat[k] = 32'(40 + k);
      in_vld = 4'b1111;
      #1;
      n_checks++; if (out_vld !== 1'b1 || in_ack !== 4'b0100) begin n_fail++; $display("FAIL mid_before: got vld %b ack %b required vld 1 ack 0100", out_vld, in_ack); end
      ap_rst = 1'b1;
      #1;
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld_drop: got %b required 0", out_vld); end
      n_checks++; if (out_dat !== 32'h0 || in_ack !== 4'b0000) begin n_fail++; $display("FAIL mid_in_reset: got dat %h ack %b required dat 0 ack 0000", out_dat, in_ack); end
      tick;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_discarded: got %b required 0", out_vld); end
      n_checks++; if (in_ack !== 4'b0001) begin n_fail++; $display("FAIL mid_prio_reset: got %b required 0001", in_ack); end
      in_vld = 4'b1000;
      #1;
      n_checks++; if (in_ack !== 4'b1000) begin n_fail++; $display("FAIL mid_in4_alone: got %b required 1000", in_ack); end
      tick;
      in_vld  = 4'b0000;
      out_ack = 1'b1;
      tick;
      tick;
   endtask

`ifdef STREAM_MERGE_STATS_EN
   task automatic test_stats;
      int acks;
      do_reset;
      acks      = 0;
      ap_start  = 1'b1;
      out_ack   = 1'b1;
      in_dat[0] = 32'h5;
      in_vld    = 4'b0001;
      for (int c = 0; c < 70000 && acks < 65537; c++) begin
         @(negedge ap_clk);
         if (in_ack[0]) acks++;
         tick;
      end
      in_vld = 4'b0000;
      n_checks++; if (acks != 65537) begin n_fail++; $display("FAIL stats_transfers: got %0d required 65537", acks); end
      n_checks++; if (stat1 !== 16'd1) begin n_fail++; $display("FAIL stats_in1_wrap: got %0d required 1", stat1); end
      n_checks++; if (stat2 !== 16'd0 || stat3 !== 16'd0 || stat4 !== 16'd0) begin n_fail++; $display("FAIL stats_others: got %0d %0d %0d required 0 0 0", stat2, stat3, stat4); end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "time limit");
   end

   initial begin
      test_reset;
      test_single_word;
      test_round_robin;
      test_full_backpressure;
      test_start_gating;
      test_reset_mid;
`ifdef STREAM_MERGE_STATS_EN
      test_stats;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
